clock_stepper: RTL and testbench

//  Drop-in replacement for the free-running prescaler feeding mother_board's clk.

---
 rtl/clock_stepper.sv | 213 +++++++++++++++++++++
 tb/tb_clock_stepper.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clock_stepper.sv
// -----------------------------------------------------------------------------
// clock_stepper
//
// Generates slow_clock for mother_board from the 100 MHz board clock. Two modes:
//   auto   (mode=0): free-running divide by RATIO, 50% duty.
//   manual (mode=1): one slow_clock period per debounced step_button press,
//                    for single-stepping the CPU.
// Mode changes only happen at a slow_clock high->low boundary, so slow_clock
// never carries a runt pulse.
//
// Parameters
//   RATIO            clk cycles per slow_clock period (even, >= 2)
//   DEBOUNCE_CYCLES  consecutive stable clk cycles before a button level is
//                    accepted (>= 1)
//
// Ports
//   clk            in   board clock
//   n_reset        in   asynchronous active-low reset
//   mode           in   asynchronous switch, 0 = auto run, 1 = manual step
//   step_button    in   asynchronous bouncy push-button, active high
//   slow_clock     out  generated clock, registered
//   manual_active  out  1 while in STEP_IDLE or STEP_HIGH
//   step_count     out  slow_clock rising edges since reset (wraps at 16 bits)
//
// Configuration macro
//   CLOCK_STEPPER_COUNT_EN  defined: step_count counter is built.
//                           undefined: no counter, step_count reads 16'h0000.
// -----------------------------------------------------------------------------
module clock_stepper #(
  parameter int RATIO           = 100,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        mode,
  input  logic        step_button,
  output logic        slow_clock,
  output logic        manual_active,
  output logic [15:0] step_count
);

  localparam int DIV_W = $clog2(RATIO);
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATIO - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(RATIO / 2 - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_IDLE = 2'd1,
    STEP_HIGH = 2'd2
  } state_t;

  // Synchronisers
  logic mode_ff1_q, mode_ff2_q;
  logic btn_ff1_q,  btn_ff2_q;

  // Debouncer
  logic             stable_q,     stable_d;
  logic             stable_dly_q;
  logic [DEB_W-1:0] deb_cnt_q,    deb_cnt_d;
  logic             press;

  // Divider / FSM
  state_t           state_q,         state_d;
  logic [DIV_W-1:0] div_q,           div_d;
  logic             slow_clock_q,    slow_clock_d;
  logic             manual_active_q, manual_active_d;

  // One-cycle pulse on the accepted rising level of the button.
  assign press = stable_q & ~stable_dly_q;

  // ---------------------------------------------------------------------------
  // Debounce: the synchronised level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive edges before it is taken; any agreeing sample
  // restarts the count.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (btn_ff2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = btn_ff2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM and divider. slow_clock only ever changes at the points below, so
  // every high phase is exactly RATIO/2 cycles and mode is looked at only when
  // slow_clock is (or is about to be) low.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    slow_clock_d = slow_clock_q;

    case (state_q)
      RUN: begin
        if (div_q == DIV_LAST) begin
          div_d        = '0;
          slow_clock_d = 1'b0;
          if (mode_ff2_q) begin
            state_d = STEP_IDLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
          if (div_q == DIV_HALF) begin
            slow_clock_d = 1'b1;
          end
        end
      end

      STEP_IDLE: begin
        div_d        = '0;
        slow_clock_d = 1'b0;
        if (!mode_ff2_q) begin
          // div restarts at 0, so RUN begins with a full low phase.
          state_d = RUN;
        end else if (press) begin
          state_d      = STEP_HIGH;
          slow_clock_d = 1'b1;
        end
      end

      STEP_HIGH: begin
        // Presses and mode changes are deliberately ignored here.
        if (div_q == DIV_HALF) begin
          div_d        = '0;
          slow_clock_d = 1'b0;
          state_d      = STEP_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d      = RUN;
        div_d        = '0;
        slow_clock_d = 1'b0;
      end
    endcase

    manual_active_d = (state_d != RUN);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mode_ff1_q      <= 1'b0;
      mode_ff2_q      <= 1'b0;
      btn_ff1_q       <= 1'b0;
      btn_ff2_q       <= 1'b0;
      stable_q        <= 1'b0;
      stable_dly_q    <= 1'b0;
      deb_cnt_q       <= '0;
      state_q         <= RUN;
      div_q           <= '0;
      slow_clock_q    <= 1'b0;
      manual_active_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others; this is what makes ff1->ff2 a real two-stage
      // synchroniser rather than a wire.
      mode_ff1_q      <= mode;
      mode_ff2_q      <= mode_ff1_q;
      btn_ff1_q       <= step_button;
      btn_ff2_q       <= btn_ff1_q;
      stable_q        <= stable_d;
      stable_dly_q    <= stable_q;
      deb_cnt_q       <= deb_cnt_d;
      state_q         <= state_d;
      div_q           <= div_d;
      slow_clock_q    <= slow_clock_d;
      manual_active_q <= manual_active_d;
    end
  end

  assign slow_clock    = slow_clock_q;
  assign manual_active = manual_active_q;

`ifdef CLOCK_STEPPER_COUNT_EN
  // Counts on the same edge that slow_clock goes high.
  logic [15:0] step_count_q, step_count_d;

  always_comb begin
    step_count_d = step_count_q;
    if (slow_clock_d && !slow_clock_q) begin
      step_count_d = step_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      step_count_q <= 16'h0000;
    end else begin
      step_count_q <= step_count_d;
    end
  end

  assign step_count = step_count_q;
`else
  assign step_count = 16'h0000;
`endif

endmodule

// File: tb/tb_clock_stepper.sv
module tb_clock_stepper;

  localparam int RATIO = 4;
  localparam int DEB   = 8;

`ifdef CLOCK_STEPPER_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        mode = 1'b0;
  logic        step_button = 1'b0;
  logic        slow_clock;
  logic        manual_active;
  logic [15:0] step_count;

  int n_vec = 0;
  int n_err = 0;

  clock_stepper #(.RATIO(RATIO), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .mode          (mode),
    .step_button   (step_button),
    .slow_clock    (slow_clock),
    .manual_active (manual_active),
    .step_count    (step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, written from the behavioural rules: RUN is a phase
  // "cycles since RUN entry mod RATIO" with slow_clock high in the upper half;
  // a manual step is a count of remaining high cycles; the debouncer accepts a
  // level after DEB consecutive disagreeing samples.
  // ---------------------------------------------------------------------------
  bit          m_mode_s1, m_mode_s2, m_btn_s1, m_btn_s2;
  bit          m_stable, m_stable_prev;
  int          m_run;
  bit          m_manual;
  int          m_phase;
  int          m_high_left;
  bit          m_slow;
  logic [15:0] m_count;
  bit          m_press, m_slow_next;

  always @(posedge clk) begin
    if (!n_reset) begin
      m_mode_s1 = 0; m_mode_s2 = 0; m_btn_s1 = 0; m_btn_s2 = 0;
      m_stable = 0; m_stable_prev = 0; m_run = 0;
      m_manual = 0; m_phase = 0; m_high_left = 0; m_slow = 0; m_count = 16'h0;
    end else begin
      m_press = m_stable && !m_stable_prev;
      if (!m_manual) begin
        if (m_phase == RATIO - 1 && m_mode_s2) begin
          m_manual = 1;
          m_phase  = 0;
          m_slow_next = 0;
        end else begin
          m_phase = (m_phase + 1) % RATIO;
          m_slow_next = (m_phase >= RATIO / 2);
        end
      end else if (m_high_left > 0) begin
        m_high_left--;
        m_slow_next = (m_high_left > 0);
      end else if (!m_mode_s2) begin
        m_manual = 0;
        m_phase  = 0;
        m_slow_next = 0;
      end else if (m_press) begin
        m_high_left = RATIO / 2;
        m_slow_next = 1;
      end else begin
        m_slow_next = 0;
      end
      if (m_slow_next && !m_slow) m_count = m_count + 16'd1;
      m_slow = m_slow_next;

      m_stable_prev = m_stable;
      if (m_btn_s2 != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = m_btn_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end

      m_mode_s2 = m_mode_s1; m_mode_s1 = mode;
      m_btn_s2  = m_btn_s1;  m_btn_s1  = step_button;
    end
    #2;
    check("model_slow_clock", {31'd0, slow_clock}, {31'd0, m_slow});
    check("model_manual_active", {31'd0, manual_active}, {31'd0, m_manual});
    check("model_step_count", {16'd0, step_count}, {16'd0, (COUNT_EN ? m_count : 16'h0)});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic at_edge(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] cnt(input int v);
    return COUNT_EN ? 32'(v) : 32'd0;
  endfunction

  initial begin
    // Reset and free-running auto mode: rises after edges 2,6,10,14,18.
    idle(3);
    check("reset_slow", {31'd0, slow_clock}, 32'd0);
    check("reset_count", {16'd0, step_count}, 32'd0);
    n_reset = 1'b1;
    at_edge(1);  check("run_e1_low", {31'd0, slow_clock}, 32'd0);
    at_edge(1);  check("run_e2_high", {31'd0, slow_clock}, 32'd1);
    check("run_e2_count", {16'd0, step_count}, cnt(1));
    at_edge(2);  check("run_e4_low", {31'd0, slow_clock}, 32'd0);
    at_edge(16); check("run_e20_low", {31'd0, slow_clock}, 32'd0);
    check("run_e20_count", {16'd0, step_count}, cnt(5));
    check("run_manual", {31'd0, manual_active}, 32'd0);

    // Switch to manual: one more rise at edge 22, STEP_IDLE from edge 24.
    @(negedge clk); mode = 1'b1;
    at_edge(2);  check("sw_e22_high", {31'd0, slow_clock}, 32'd1);
    at_edge(1);  check("sw_e23_high", {31'd0, slow_clock}, 32'd1);
    check("sw_e23_auto", {31'd0, manual_active}, 32'd0);
    at_edge(1);  check("sw_e24_low", {31'd0, slow_clock}, 32'd0);
    check("sw_e24_manual", {31'd0, manual_active}, 32'd1);
    idle(10);
    check("sw_count", {16'd0, step_count}, cnt(6));

    // Clean press: slow_clock high after edges 11 and 12 only.
    @(negedge clk); step_button = 1'b1;
    at_edge(10); check("press_e10_low", {31'd0, slow_clock}, 32'd0);
    at_edge(1);  check("press_e11_high", {31'd0, slow_clock}, 32'd1);
    at_edge(1);  check("press_e12_high", {31'd0, slow_clock}, 32'd1);
    at_edge(1);  check("press_e13_low", {31'd0, slow_clock}, 32'd0);
    idle(30);
    check("press_hold_count", {16'd0, step_count}, cnt(7));
    step_button = 1'b0;
    idle(20);

    // Bounce: 3-cycle runs never reach the debounce threshold.
    for (int i = 0; i < 10; i++) begin
      step_button = ~step_button;
      idle(3);
    end
    idle(15);
    check("bounce_count", {16'd0, step_count}, cnt(7));
    check("bounce_slow", {31'd0, slow_clock}, 32'd0);

    // Long hold gives one pulse; release and re-press gives a second.
    step_button = 1'b1; idle(40);
    check("hold_count", {16'd0, step_count}, cnt(8));
    step_button = 1'b0; idle(20);
    step_button = 1'b1; idle(20);
    check("repress_count", {16'd0, step_count}, cnt(9));
    step_button = 1'b0; idle(20);

    // Back to auto: RUN entered at edge 3, first rise at edge 5.
    @(negedge clk); mode = 1'b0;
    at_edge(2);  check("auto_e2_manual", {31'd0, manual_active}, 32'd1);
    at_edge(1);  check("auto_e3_manual", {31'd0, manual_active}, 32'd0);
    at_edge(1);  check("auto_e4_low", {31'd0, slow_clock}, 32'd0);
    at_edge(1);  check("auto_e5_high", {31'd0, slow_clock}, 32'd1);
    check("auto_count", {16'd0, step_count}, cnt(10));

    // Asynchronous reset mid-high, away from any clock edge.
    #1 n_reset = 1'b0;
    #1;
    check("async_rst_slow", {31'd0, slow_clock}, 32'd0);
    check("async_rst_count", {16'd0, step_count}, 32'd0);
    check("async_rst_manual", {31'd0, manual_active}, 32'd0);
    idle(2);
    n_reset = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
